cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cpu_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: fetch/execute sequencer driving an accumulator datapath.
// Define CPU_CTRL_WDT_EN to add a fetch watchdog that halts with fault.
module cpu_ctrl #(
   parameter int WIDTH          = 8,
   parameter int IWIDTH         = 4,
   parameter int REG_F_SEL_SIZE = 4,
   parameter int IN_B_SEL_SIZE  = 2
) (
   input  logic                      clk,
   input  logic                      pc_rst,
   input  logic                      start,
   output logic                      imem_req,
   output logic [WIDTH-1:0]          imem_addr,
   input  logic                      imem_ack,
   input  logic [15:0]               imem_data,
   input  logic                      flag_z_in,
   output logic [IWIDTH-1:0]         alu_out,
   output logic                      en_acc,
   output logic [REG_F_SEL_SIZE-1:0] reg_f_sel,
   output logic                      en_reg_f,
   output logic [IN_B_SEL_SIZE-1:0]  in_b_sel,
   output logic [WIDTH-1:0]          imm,
   output logic [WIDTH-1:0]          d_mem_addr,
   output logic                      d_mem_addr_mode,
   output logic                      en_d_mem,
   output logic                      flag_clr,
   output logic [WIDTH-1:0]          pc,
   output logic                      busy,
   output logic                      halted,
   output logic                      fault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [15:0]      ir_q, ir_d;

   logic [3:0] op;
   logic [3:0] mode;
   logic [7:0] operand;

   assign op      = ir_q[15:12];
   assign mode    = ir_q[11:8];
   assign operand = ir_q[7:0];

`ifdef CPU_CTRL_WDT_EN
   logic       fault_q, fault_d;
   logic [3:0] wdt_q, wdt_d;
`endif

   always_ff @(posedge clk or negedge pc_rst) begin
      if (!pc_rst) begin
         state_q <= IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
`ifdef CPU_CTRL_WDT_EN
         fault_q <= 1'b0;
         wdt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
`ifdef CPU_CTRL_WDT_EN
         fault_q <= fault_d;
         wdt_q   <= wdt_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      imem_req = 1'b0;
      flag_clr = 1'b0;
      en_acc   = 1'b0;
      en_reg_f = 1'b0;
      en_d_mem = 1'b0;
`ifdef CPU_CTRL_WDT_EN
      fault_d  = fault_q;
      wdt_d    = '0;
`endif
      unique case (state_q)
         IDLE, HALT: begin
            if (start) begin
               state_d  = FETCH;
               pc_d     = '0;
               flag_clr = 1'b1;
`ifdef CPU_CTRL_WDT_EN
               fault_d  = 1'b0;
`endif
            end
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_d    = imem_data;
               state_d = EXEC;
            end
`ifdef CPU_CTRL_WDT_EN
            // sixteenth unacknowledged fetch cycle gives up
            else if (wdt_q == 4'hF) begin
               state_d = HALT;
               fault_d = 1'b1;
            end else begin
               wdt_d = wdt_q + 4'd1;
            end
`endif
         end
         EXEC: begin
            state_d = FETCH;
            unique case (1'b1)
               (op < 4'hC): begin
                  en_acc = 1'b1;
                  pc_d   = pc_q + WIDTH'(1);
               end
               (op == 4'hC): begin
                  en_reg_f = ~mode[3];
                  en_d_mem = mode[3];
                  pc_d     = pc_q + WIDTH'(1);
               end
               (op == 4'hD): begin
                  pc_d = WIDTH'(operand);
               end
               (op == 4'hE): begin
                  pc_d = flag_z_in ? WIDTH'(operand)
                                   : pc_q + WIDTH'(1);
               end
               (op == 4'hF): begin
                  state_d = HALT;
               end
            endcase
         end
      endcase
   end

   assign imem_addr       = pc_q;
   assign pc              = pc_q;
   assign busy            = (state_q == FETCH) || (state_q == EXEC);
   assign halted          = (state_q == HALT);
   assign alu_out         = IWIDTH'(op);
   assign in_b_sel        = IN_B_SEL_SIZE'(mode[1:0]);
   assign d_mem_addr_mode = mode[2];
   assign imm             = WIDTH'(operand);
   assign d_mem_addr      = WIDTH'(operand);
   assign reg_f_sel       = REG_F_SEL_SIZE'(operand[3:0]);

`ifdef CPU_CTRL_WDT_EN
   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl with a small instruction memory model.
// Checks run 1 time unit after each rising edge.
`timescale 1ns/1ps
module tb_cpu_ctrl;

   logic       clk = 1'b0;
   logic       pc_rst;
   logic       start;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ack;
   logic [15:0] imem_data;
   logic       flag_z_in;
   logic [3:0] alu_out;
   logic       en_acc;
   logic [3:0] reg_f_sel;
   logic       en_reg_f;
   logic [1:0] in_b_sel;
   logic [7:0] imm;
   logic [7:0] d_mem_addr;
   logic       d_mem_addr_mode;
   logic       en_d_mem;
   logic       flag_clr;
   logic [7:0] pc;
   logic       busy;
   logic       halted;
   logic       fault;

   logic [15:0] mem [256];
   int          ack_mode;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // 0: no ack, 1: ack whenever requested, 2: ack stuck high
   assign imem_ack  = (ack_mode == 2) ? 1'b1 :
                      (ack_mode == 1) ? imem_req : 1'b0;
   assign imem_data = mem[imem_addr];

   cpu_ctrl dut (
      .clk(clk), .pc_rst(pc_rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data),
      .flag_z_in(flag_z_in), .alu_out(alu_out),
      .en_acc(en_acc), .reg_f_sel(reg_f_sel),
      .en_reg_f(en_reg_f), .in_b_sel(in_b_sel),
      .imm(imm), .d_mem_addr(d_mem_addr),
      .d_mem_addr_mode(d_mem_addr_mode),
      .en_d_mem(en_d_mem), .flag_clr(flag_clr),
      .pc(pc), .busy(busy), .halted(halted),
      .fault(fault)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic no_strobes(input string tag);
      chk({tag, "_acc"}, en_acc, 0);
      chk({tag, "_regf"}, en_reg_f, 0);
      chk({tag, "_dmem"}, en_d_mem, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
      pc_rst    = 1'b0;
      start     = 1'b0;
      flag_z_in = 1'b1;
      ack_mode  = 1;
      repeat (2) step();
      chk("rst_pc", pc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_halted", halted, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_fault", fault, 0);
      chk("rst_alu", alu_out, 0);
      chk("rst_imm", imm, 0);
      chk("rst_clr", flag_clr, 0);
      no_strobes("rst");
      pc_rst = 1'b1;
      step();
      chk("idle_busy", busy, 0);

      // program A: ALU op 1 imm 5, then HLT
      mem[0] = 16'h1005;
      mem[1] = 16'hF000;
      start = 1'b1;
      #1;
      chk("a_clr", flag_clr, 1);
      step();
      chk("a_f0_req", imem_req, 1);
      chk("a_f0_addr", imem_addr, 0);
      chk("a_f0_busy", busy, 1);
      chk("a_f0_clr", flag_clr, 0);
      chk("a_f0_acc", en_acc, 0);
      step();
      chk("a_e0_acc", en_acc, 1);
      chk("a_e0_alu", alu_out, 1);
      chk("a_e0_imm", imm, 8'h05);
      chk("a_e0_req", imem_req, 0);
      chk("a_e0_clr", flag_clr, 0);
      step();
      start = 1'b0;
      chk("a_f1_addr", imem_addr, 8'h01);
      chk("a_f1_acc", en_acc, 0);
      step();
      no_strobes("a_e1");
      step();
      chk("a_halted", halted, 1);
      chk("a_pc", pc, 8'h01);
      chk("a_busy", busy, 0);
      step();
      chk("a_stay", halted, 1);

      // program B: ST dmem, ST regf, JZ taken, JZ not, JMP FF, ALU
      mem[8'h00] = 16'hC820;
      mem[8'h01] = 16'hC303;
      mem[8'h02] = 16'hE040;
      mem[8'h40] = 16'hE050;
      mem[8'h41] = 16'hD0FF;
      mem[8'hFF] = 16'h2007;
      start = 1'b1;
      #1;
      chk("b_clr", flag_clr, 1);
      step();
      start = 1'b0;
      chk("b_f0_addr", imem_addr, 0);
      chk("b_f0_halted", halted, 0);
      step();
      chk("b_st_dmem", en_d_mem, 1);
      chk("b_st_regf", en_reg_f, 0);
      chk("b_st_acc", en_acc, 0);
      chk("b_st_addr", d_mem_addr, 8'h20);
      chk("b_st_mode", d_mem_addr_mode, 0);
      step();
      chk("b_f1_dmem", en_d_mem, 0);
      chk("b_f1_addr", imem_addr, 8'h01);
      step();
      chk("b_st2_regf", en_reg_f, 1);
      chk("b_st2_dmem", en_d_mem, 0);
      chk("b_st2_sel", reg_f_sel, 3);
      chk("b_st2_inb", in_b_sel, 3);
      step();
      step();
      no_strobes("b_jz1");
      step();
      chk("b_jz_taken", imem_addr, 8'h40);
      flag_z_in = 1'b0;
      step();
      step();
      chk("b_jz_not", imem_addr, 8'h41);
      step();
      step();
      chk("b_jmp", imem_addr, 8'hFF);
      step();
      chk("b_alu_acc", en_acc, 1);
      chk("b_alu_op", alu_out, 2);
      step();
      chk("b_wrap", imem_addr, 8'h00);
      chk("b_wrap_fault", fault, 0);
      chk("b_wrap_ack", imem_ack, 1);

      // asynchronous reset while an ack is pending in FETCH
      ack_mode = 2;
      pc_rst = 1'b0;
      #1;
      chk("r_busy", busy, 0);
      chk("r_req", imem_req, 0);
      no_strobes("r");
      step();
      pc_rst = 1'b1;
      step();
      chk("r_rel_busy", busy, 0);
      chk("r_rel_alu", alu_out, 0);
      no_strobes("r_rel");
      step();
      chk("r_rel2_busy", busy, 0);
      chk("r_rel2_pc", pc, 0);
      no_strobes("r_rel2");

      // fetch with no ack at all
      ack_mode = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("w_f1_req", imem_req, 1);
      repeat (15) step();
      chk("w_f16_req", imem_req, 1);
      chk("w_f16_fault", fault, 0);
      step();
`ifdef CPU_CTRL_WDT_EN
      chk("w_fault", fault, 1);
      chk("w_halted", halted, 1);
      chk("w_req", imem_req, 0);
`else
      chk("w_fault", fault, 0);
      chk("w_halted", halted, 0);
      chk("w_req", imem_req, 1);
`endif
      step();
      no_strobes("w_end");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
